// File: rtl/flag_ctrl_pkg.sv
// Shared types for the flag/flip write controller and its shadow stack.
package flag_ctrl_pkg;

  typedef enum logic [1:0] {
    CTX_NONE = 2'd0,
    CTX_PUSH = 2'd1,
    CTX_POP  = 2'd2,
    CTX_RSVD = 2'd3
  } ctx_op_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  typedef struct packed {
    logic flip;
    logic flag;
  } ctx_entry_t;

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of {flip,flag} context entries; push when full is dropped, pop when empty ignored.
// Occupancy updates on the clock edge; top_dat is combinational from the current top.
module flag_shadow_stack
  import flag_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         push,
  input  logic                         pop,
  input  ctx_entry_t                   push_dat,
  output ctx_entry_t                   top_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ctx_entry_t      mem [DEPTH];
  logic [PW-1:0]   cnt_q;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign full    = (cnt_q == PW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign depth   = cnt_q;
  assign wr_idx  = AW'(cnt_q);
  assign rd_idx  = AW'(cnt_q - PW'(1));
  assign top_dat = mem[rd_idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + PW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - PW'(1);
    end
  end

  // Entry storage needs no reset: only slots below cnt_q are ever read.
  always_ff @(posedge CLK) begin
    if (push && !full) begin
      mem[wr_idx] <= push_dat;
    end
  end

endmodule

// File: rtl/flag_flip_ctrl.sv
// Write controller for the flag/flip register pair: INIT after reset, ALU/control grants, LIFO save/restore.
// Writes land on *_cur one cycle after the strobe (restore two cycles after POP); FLAG_FLIP_CTRL_BYPASS_EN forwards write data onto *_view.
// Requesters hold req/val until gnt; no grants in INIT, RESTORE or a POP cycle.
module flag_flip_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter int   STACK_DEPTH = 4,
  parameter logic INIT_FLAG   = 1'b0,
  parameter logic INIT_FLIP   = 1'b0
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               alu_req,
  input  logic                               alu_val,
  output logic                               alu_gnt,
  input  logic                               ctl_req,
  input  logic                               ctl_val,
  output logic                               ctl_gnt,
  input  ctx_op_t                            ctx_op,
  output logic                               ctx_rdy,
  input  logic                               flag_cur,
  input  logic                               flip_cur,
  output logic                               flagin,
  output logic                               writeFlag,
  output logic                               flipin,
  output logic                               writeFlip,
  output logic                               flag_view,
  output logic                               flip_view,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               err_ovf,
  output logic                               err_unf
);

  state_t     state_q, state_d;
  ctx_entry_t restore_q;
  ctx_entry_t push_dat;
  ctx_entry_t top_dat;
  logic       stk_push, stk_pop, stk_full, stk_empty;
  logic       set_ovf, set_unf;

  flag_shadow_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dat (push_dat),
    .top_dat  (top_dat),
    .full     (stk_full),
    .empty    (stk_empty),
    .depth    (depth)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_INIT;
      restore_q <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (stk_pop) restore_q <= top_dat;
      if (set_ovf) err_ovf <= 1'b1;
      if (set_unf) err_unf <= 1'b1;
    end
  end

  // Reset gates every strobe combinationally: the register pair must see no writes while held.
  always_comb begin
    state_d   = state_q;
    alu_gnt   = 1'b0;
    ctl_gnt   = 1'b0;
    ctx_rdy   = 1'b0;
    writeFlag = 1'b0;
    writeFlip = 1'b0;
    flagin    = 1'b0;
    flipin    = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    push_dat  = '0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (RST_N) begin
      unique case (state_q)
        ST_INIT: begin
          writeFlag = 1'b1;
          writeFlip = 1'b1;
          flagin    = INIT_FLAG;
          flipin    = INIT_FLIP;
          state_d   = ST_IDLE;
        end
        ST_IDLE: begin
          ctx_rdy = 1'b1;
          if (ctx_op == CTX_POP) begin
            if (stk_empty) begin
              set_unf = 1'b1;
            end else begin
              stk_pop = 1'b1;
              state_d = ST_RESTORE;
            end
          end else begin
            alu_gnt   = alu_req;
            ctl_gnt   = ctl_req;
            writeFlag = alu_req;
            writeFlip = ctl_req;
            flagin    = alu_req ? alu_val : 1'b0;
            flipin    = ctl_req ? ctl_val : 1'b0;
            if (ctx_op == CTX_PUSH) begin
              // Saved context reflects this cycle's granted writes.
              stk_push      = 1'b1;
              set_ovf       = stk_full;
              push_dat.flag = alu_req ? alu_val : flag_cur;
              push_dat.flip = ctl_req ? ctl_val : flip_cur;
            end
          end
        end
        ST_RESTORE: begin
          writeFlag = 1'b1;
          writeFlip = 1'b1;
          flagin    = restore_q.flag;
          flipin    = restore_q.flip;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

`ifdef FLAG_FLIP_CTRL_BYPASS_EN
  assign flag_view = writeFlag ? flagin : flag_cur;
  assign flip_view = writeFlip ? flipin : flip_cur;
`else
  assign flag_view = flag_cur;
  assign flip_view = flip_cur;
`endif

endmodule

// File: tb/tb_flag_flip_ctrl.sv
// Directed bench for flag_flip_ctrl with a behavioural model of the unreset flag/flip register pair.
module tb_flag_flip_ctrl;
  import flag_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       alu_req, alu_val, alu_gnt;
  logic       ctl_req, ctl_val, ctl_gnt;
  ctx_op_t    ctx_op;
  logic       ctx_rdy;
  logic       flag_reg, flip_reg;
  logic       flagin, writeFlag, flipin, writeFlip;
  logic       flag_view, flip_view;
  logic [2:0] depth;
  logic       err_ovf, err_unf;

  int total = 0;
  int bad   = 0;

  flag_flip_ctrl #(
    .STACK_DEPTH (4),
    .INIT_FLAG   (1'b1),
    .INIT_FLIP   (1'b0)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .alu_req   (alu_req),
    .alu_val   (alu_val),
    .alu_gnt   (alu_gnt),
    .ctl_req   (ctl_req),
    .ctl_val   (ctl_val),
    .ctl_gnt   (ctl_gnt),
    .ctx_op    (ctx_op),
    .ctx_rdy   (ctx_rdy),
    .flag_cur  (flag_reg),
    .flip_cur  (flip_reg),
    .flagin    (flagin),
    .writeFlag (writeFlag),
    .flipin    (flipin),
    .writeFlip (writeFlip),
    .flag_view (flag_view),
    .flip_view (flip_view),
    .depth     (depth),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 CLK = ~CLK;

  // Register pair: no reset, written on strobe.
  always @(posedge CLK) begin
    if (writeFlag) flag_reg <= flagin;
    if (writeFlip) flip_reg <= flipin;
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    total++; if (writeFlag !== 1'b0) begin bad++; $display("FAIL rst_wflag got=%b want=0", writeFlag); end
    total++; if (writeFlip !== 1'b0) begin bad++; $display("FAIL rst_wflip got=%b want=0", writeFlip); end
    total++; if (ctx_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%b want=0", ctx_rdy); end
    total++; if (depth !== 3'd0) begin bad++; $display("FAIL rst_depth got=%0d want=0", depth); end
    total++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b want=00", err_ovf, err_unf); end
    nxt();
    RST_N = 1'b1;
    @(negedge CLK);
    total++; if (writeFlag !== 1'b1 || writeFlip !== 1'b1) begin bad++; $display("FAIL init_strobes got=%b%b want=11", writeFlag, writeFlip); end
    total++; if (flagin !== 1'b1 || flipin !== 1'b0) begin bad++; $display("FAIL init_data got=%b%b want=10", flagin, flipin); end
    total++; if (ctx_rdy !== 1'b0) begin bad++; $display("FAIL init_rdy got=%b want=0", ctx_rdy); end
    nxt();
    @(negedge CLK);
    total++; if (ctx_rdy !== 1'b1) begin bad++; $display("FAIL idle_rdy got=%b want=1", ctx_rdy); end
    total++; if (flag_reg !== 1'b1 || flip_reg !== 1'b0) begin bad++; $display("FAIL init_regs got=%b%b want=10", flag_reg, flip_reg); end
    nxt();
  endtask

  task automatic test_dual_write();
    logic exp_view;
    alu_req = 1'b1; alu_val = 1'b0;
    @(negedge CLK);
    total++; if (alu_gnt !== 1'b1 || flagin !== 1'b0) begin bad++; $display("FAIL clr_flag got=gnt%b d%b want=gnt1 d0", alu_gnt, flagin); end
    nxt();
    alu_req = 1'b1; alu_val = 1'b1; ctl_req = 1'b1; ctl_val = 1'b1;
`ifdef FLAG_FLIP_CTRL_BYPASS_EN
    exp_view = 1'b1;
`else
    exp_view = 1'b0;
`endif
    @(negedge CLK);
    total++; if (alu_gnt !== 1'b1 || ctl_gnt !== 1'b1) begin bad++; $display("FAIL dual_gnt got=%b%b want=11", alu_gnt, ctl_gnt); end
    total++; if (writeFlag !== 1'b1 || writeFlip !== 1'b1) begin bad++; $display("FAIL dual_strobe got=%b%b want=11", writeFlag, writeFlip); end
    total++; if (flagin !== 1'b1 || flipin !== 1'b1) begin bad++; $display("FAIL dual_data got=%b%b want=11", flagin, flipin); end
    total++; if (flag_view !== exp_view || flip_view !== exp_view) begin bad++; $display("FAIL dual_view got=%b%b want=%b%b", flag_view, flip_view, exp_view, exp_view); end
    nxt();
    alu_req = 1'b0; ctl_req = 1'b0;
    @(negedge CLK);
    total++; if (flag_reg !== 1'b1 || flip_reg !== 1'b1) begin bad++; $display("FAIL dual_regs got=%b%b want=11", flag_reg, flip_reg); end
    total++; if (writeFlag !== 1'b0 || alu_gnt !== 1'b0) begin bad++; $display("FAIL dual_idle got=%b%b want=00", writeFlag, alu_gnt); end
    nxt();
  endtask

  task automatic test_push_pop();
    alu_req = 1'b1; alu_val = 1'b1; ctl_req = 1'b1; ctl_val = 1'b0;
    nxt();
    alu_req = 1'b0; ctl_req = 1'b0; ctx_op = CTX_PUSH;
    @(negedge CLK);
    total++; if (ctx_rdy !== 1'b1 || depth !== 3'd0) begin bad++; $display("FAIL push_cyc got=rdy%b d%0d want=rdy1 d0", ctx_rdy, depth); end
    nxt();
    ctx_op = CTX_NONE; alu_req = 1'b1; alu_val = 1'b0;
    @(negedge CLK);
    total++; if (depth !== 3'd1) begin bad++; $display("FAIL push_depth got=%0d want=1", depth); end
    nxt();
    ctx_op = CTX_POP;
    @(negedge CLK);
    total++; if (alu_gnt !== 1'b0 || writeFlag !== 1'b0) begin bad++; $display("FAIL pop_nognt got=%b%b want=00", alu_gnt, writeFlag); end
    total++; if (flag_reg !== 1'b0) begin bad++; $display("FAIL pre_pop_flag got=%b want=0", flag_reg); end
    nxt();
    ctx_op = CTX_NONE;
    @(negedge CLK);
    total++; if (writeFlag !== 1'b1 || writeFlip !== 1'b1) begin bad++; $display("FAIL rest_strobe got=%b%b want=11", writeFlag, writeFlip); end
    total++; if (flagin !== 1'b1 || flipin !== 1'b0) begin bad++; $display("FAIL rest_data got=%b%b want=10", flagin, flipin); end
    total++; if (alu_gnt !== 1'b0 || ctx_rdy !== 1'b0) begin bad++; $display("FAIL rest_gnt got=%b%b want=00", alu_gnt, ctx_rdy); end
    total++; if (depth !== 3'd0) begin bad++; $display("FAIL rest_depth got=%0d want=0", depth); end
    nxt();
    @(negedge CLK);
    total++; if (flag_reg !== 1'b1 || flip_reg !== 1'b0) begin bad++; $display("FAIL rest_regs got=%b%b want=10", flag_reg, flip_reg); end
    total++; if (alu_gnt !== 1'b1) begin bad++; $display("FAIL held_gnt got=%b want=1", alu_gnt); end
    nxt();
    alu_req = 1'b0;
  endtask

  task automatic test_push_with_write();
    ctx_op = CTX_PUSH; alu_req = 1'b1; alu_val = 1'b1;
    @(negedge CLK);
    total++; if (alu_gnt !== 1'b1 || flag_reg !== 1'b0) begin bad++; $display("FAIL pw_gnt got=%b f%b want=1 f0", alu_gnt, flag_reg); end
    nxt();
    ctx_op = CTX_NONE; alu_req = 1'b1; alu_val = 1'b0;
    @(negedge CLK);
    total++; if (depth !== 3'd1 || flag_reg !== 1'b1) begin bad++; $display("FAIL pw_after got=d%0d f%b want=d1 f1", depth, flag_reg); end
    nxt();
    alu_req = 1'b0; ctx_op = CTX_POP;
    @(negedge CLK);
    nxt();
    ctx_op = CTX_NONE;
    @(negedge CLK);
    total++; if (writeFlag !== 1'b1 || flagin !== 1'b1 || flipin !== 1'b0) begin bad++; $display("FAIL pw_entry got=w%b %b%b want=w1 10", writeFlag, flagin, flipin); end
    nxt();
  endtask

  task automatic test_overflow_underflow();
    logic [1:0] e;
    for (int i = 0; i < 5; i++) begin
      ctx_op = CTX_PUSH; alu_req = 1'b1; alu_val = i[0]; ctl_req = 1'b1; ctl_val = i[1];
      nxt();
    end
    ctx_op = CTX_NONE; alu_req = 1'b0; ctl_req = 1'b0;
    @(negedge CLK);
    total++; if (depth !== 3'd4) begin bad++; $display("FAIL ovf_depth got=%0d want=4", depth); end
    total++; if (err_ovf !== 1'b1 || err_unf !== 1'b0) begin bad++; $display("FAIL ovf_err got=%b%b want=10", err_ovf, err_unf); end
    for (int k = 0; k < 4; k++) begin
      nxt();
      ctx_op = CTX_POP;
      @(negedge CLK);
      nxt();
      ctx_op = CTX_NONE;
      e = 2'(3 - k);
      @(negedge CLK);
      total++; if (writeFlag !== 1'b1 || flagin !== e[0] || flipin !== e[1]) begin bad++; $display("FAIL pop%0d_data got=w%b %b%b want=w1 %b%b", k, writeFlag, flipin, flagin, e[1], e[0]); end
      total++; if (depth !== 3'(3 - k)) begin bad++; $display("FAIL pop%0d_depth got=%0d want=%0d", k, depth, 3 - k); end
    end
    nxt();
    ctx_op = CTX_POP;
    @(negedge CLK);
    total++; if (writeFlag !== 1'b0 || writeFlip !== 1'b0) begin bad++; $display("FAIL unf_write got=%b%b want=00", writeFlag, writeFlip); end
    nxt();
    ctx_op = CTX_NONE;
    @(negedge CLK);
    total++; if (err_unf !== 1'b1 || err_ovf !== 1'b1) begin bad++; $display("FAIL unf_err got=%b%b want=11", err_ovf, err_unf); end
    total++; if (ctx_rdy !== 1'b1 || depth !== 3'd0) begin bad++; $display("FAIL unf_idle got=rdy%b d%0d want=rdy1 d0", ctx_rdy, depth); end
    nxt();
  endtask

  task automatic test_reset_mid_restore();
    ctx_op = CTX_PUSH;
    nxt();
    ctx_op = CTX_POP;
    nxt();
    ctx_op = CTX_NONE;
    RST_N = 1'b0;
    #1;
    total++; if (writeFlag !== 1'b0 || writeFlip !== 1'b0) begin bad++; $display("FAIL mid_rst_strobe got=%b%b want=00", writeFlag, writeFlip); end
    total++; if (depth !== 3'd0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin bad++; $display("FAIL mid_rst_state got=d%0d e%b%b want=d0 e00", depth, err_ovf, err_unf); end
    @(negedge CLK);
    nxt();
    RST_N = 1'b1;
    @(negedge CLK);
    total++; if (writeFlag !== 1'b1 || flagin !== 1'b1 || flipin !== 1'b0) begin bad++; $display("FAIL reinit got=w%b %b%b want=w1 10", writeFlag, flagin, flipin); end
    nxt();
    @(negedge CLK);
    total++; if (ctx_rdy !== 1'b1 || flag_reg !== 1'b1 || flip_reg !== 1'b0 || depth !== 3'd0) begin bad++; $display("FAIL reinit_idle got=rdy%b %b%b d%0d want=rdy1 10 d0", ctx_rdy, flag_reg, flip_reg, depth); end
    nxt();
  endtask

  initial begin
    RST_N = 1'b0;
    alu_req = 1'b0; alu_val = 1'b0;
    ctl_req = 1'b0; ctl_val = 1'b0;
    ctx_op = CTX_NONE;
    nxt();
    test_reset();
    test_dual_write();
    test_push_pop();
    test_push_with_write();
    test_overflow_underflow();
    test_reset_mid_restore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
